// File: rtl/bd_ser_pkg.sv
// Shared definitions for the BD word serializer.
// This file holds the leaf width table, the chunk-count and mask helpers,
// and the out_code field layout.
// Optional feature macro used by the top: BD_SER_DROP_COUNT_EN.
package bd_ser_pkg;

    // Input word geometry
    localparam int NLeafCode   = 4;
    localparam int NPayloadIn  = 38;

    // Output chunk geometry
    localparam int NPayloadOut = 24;
    localparam int NChunkIdx   = 3;
    localparam int NCode       = NLeafCode + NChunkIdx + 1;

    // Leaf code that is accepted but never forwarded
    localparam logic [NLeafCode-1:0] InvalidLeaf = 4'd15;

    typedef logic [NLeafCode-1:0]   leaf_t;
    typedef logic [NChunkIdx-1:0]   chunk_idx_t;
    typedef logic [NPayloadIn-1:0]  payload_in_t;
    typedef logic [NPayloadOut-1:0] payload_out_t;

    // Field layout of the 8-bit output code, MSB first
    typedef struct packed {
        leaf_t      leaf;
        chunk_idx_t chunk_idx;
        logic       last;
    } out_code_t;

    // Serializer control states
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Meaningful payload width of each leaf; zero marks an unused leaf.
    // The invalid leaf also carries zero because it is never sent.
    localparam int unsigned LEAF_WIDTH [16] = '{
        8,   // leaf 0
        16,  // leaf 1
        20,  // leaf 2
        24,  // leaf 3
        30,  // leaf 4
        38,  // leaf 5
        32,  // leaf 6
        12,  // leaf 7
        0,   // leaf 8
        0,   // leaf 9
        25,  // leaf 10
        0,   // leaf 11
        0,   // leaf 12
        0,   // leaf 13
        0,   // leaf 14
        0    // leaf 15 (invalid)
    };

    // Number of output chunks for a leaf; unused leaves still send one
    // all-zero chunk so the receiver sees every accepted word.
    function automatic chunk_idx_t leaf_nchunks(input leaf_t leaf);
        int unsigned width;
        width = LEAF_WIDTH[leaf];
        if (width == 0) begin
            return chunk_idx_t'(1);
        end
        return chunk_idx_t'((width + NPayloadOut - 1) / NPayloadOut);
    endfunction

    // Bit mask covering the meaningful payload bits of a leaf
    function automatic payload_in_t leaf_mask(input leaf_t leaf);
        int unsigned width;
        width = LEAF_WIDTH[leaf];
        if (width >= NPayloadIn) begin
            return '1;
        end
        return (NPayloadIn'(1) << width) - NPayloadIn'(1);
    endfunction

endpackage

// File: rtl/bd_word_serializer_chunk_select.sv
// Chunk picker for the BD word serializer.
// Masks the held payload down to the leaf's real width, then selects the
// 24-bit slice addressed by the current chunk index.
module bd_chunk_select
    import bd_ser_pkg::*;
(
    input  logic [NLeafCode-1:0]   leaf_i,
    input  logic [NPayloadIn-1:0]  payload_i,
    input  logic [NChunkIdx-1:0]   chunk_idx_i,
    output logic [NPayloadOut-1:0] chunk_o
);

    // Room for every chunk index the code field can express, so any index
    // past the real data simply reads zeros.
    localparam int NPadBits = NPayloadOut << NChunkIdx;

    logic [NPayloadIn-1:0] maskedPayload;
    logic [NPadBits-1:0]   paddedPayload;

    // Zero the unused upper bits and slice out the addressed chunk
    always_comb begin
        maskedPayload = payload_i & leaf_mask(leaf_i);
        paddedPayload = '0;
        paddedPayload[NPayloadIn-1:0] = maskedPayload;
        chunk_o = paddedPayload[chunk_idx_i * NPayloadOut +: NPayloadOut];
    end

endmodule

// File: rtl/bd_word_serializer.sv
// BD word serializer: splits one decoded BD word into 24-bit chunks for the
// upstream PC word FIFO, one chunk per output handshake.
// Optional feature: define BD_SER_DROP_COUNT_EN to build the saturating
// counter of dropped invalid-leaf words; otherwise drop_count reads zero.
module bd_word_serializer
    import bd_ser_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NLeafCode-1:0]   in_leaf_code,
    input  logic [NPayloadIn-1:0]  in_payload,
    input  logic                   in_v,
    output logic                   in_a,
    output logic [NCode-1:0]       out_code,
    output logic [NPayloadOut-1:0] out_payload,
    output logic                   out_v,
    input  logic                   out_a,
    output logic [15:0]            drop_count
);

    ser_state_t            state_q, state_d;
    leaf_t                 hold_leaf_q, hold_leaf_d;
    payload_in_t           hold_payload_q, hold_payload_d;
    chunk_idx_t            chunk_idx_q, chunk_idx_d;
    chunk_idx_t            nchunks_q, nchunks_d;

    logic                  lastChunk;
    logic                  inXfer;
    logic                  inLeafValid;
    payload_out_t          chunkData;
    out_code_t             codeWord;

    assign lastChunk   = (chunk_idx_q == (nchunks_q - chunk_idx_t'(1)));
    assign inXfer      = in_v & in_a;
    assign inLeafValid = (in_leaf_code != InvalidLeaf);

    bd_chunk_select u_chunk_select (
        .leaf_i      (hold_leaf_q),
        .payload_i   (hold_payload_q),
        .chunk_idx_i (chunk_idx_q),
        .chunk_o     (chunkData)
    );

    // State register; a reset abandons any partially sent word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold registers; their content is only looked at while sending
    always_ff @(posedge clk) begin
        hold_leaf_q    <= hold_leaf_d;
        hold_payload_q <= hold_payload_d;
        chunk_idx_q    <= chunk_idx_d;
        nchunks_q      <= nchunks_d;
    end

    // Next-state logic: capture, advance chunk, or hand over to the next word
    always_comb begin
        state_d        = state_q;
        hold_leaf_d    = hold_leaf_q;
        hold_payload_d = hold_payload_q;
        chunk_idx_d    = chunk_idx_q;
        nchunks_d      = nchunks_q;

        case (state_q)
            IDLE: begin
                if (inXfer && inLeafValid) begin
                    hold_leaf_d    = in_leaf_code;
                    hold_payload_d = in_payload;
                    chunk_idx_d    = '0;
                    nchunks_d      = leaf_nchunks(in_leaf_code);
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (out_a) begin
                    if (lastChunk) begin
                        if (inXfer && inLeafValid) begin
                            hold_leaf_d    = in_leaf_code;
                            hold_payload_d = in_payload;
                            chunk_idx_d    = '0;
                            nchunks_d      = leaf_nchunks(in_leaf_code);
                            state_d        = SEND;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        chunk_idx_d = chunk_idx_q + chunk_idx_t'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic; in_a never looks at in_v, and idle outputs read as zero
    always_comb begin
        out_v       = 1'b0;
        in_a        = 1'b1;
        out_code    = '0;
        out_payload = '0;
        codeWord    = '{leaf: hold_leaf_q, chunk_idx: chunk_idx_q, last: lastChunk};

        case (state_q)
            IDLE: begin
                out_v = 1'b0;
                in_a  = 1'b1;
            end
            SEND: begin
                out_v       = 1'b1;
                in_a        = out_a & lastChunk;
                out_code    = codeWord;
                out_payload = chunkData;
            end
            default: begin
                out_v = 1'b0;
                in_a  = 1'b1;
            end
        endcase
    end

`ifdef BD_SER_DROP_COUNT_EN
    logic        dropWord;
    logic [15:0] drop_count_q, drop_count_d;

    assign dropWord = inXfer & ~inLeafValid;

    // Saturating count of accepted invalid-leaf words
    always_comb begin
        drop_count_d = drop_count_q;
        if (dropWord && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // Drop counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = '0;
`endif

endmodule
